// File: rtl/ram_arbiter_2x1_if.sv
// One requester port of the RAM arbiter: byte-addressed req/gnt request side
// plus the registered read-return strobe and data.
`timescale 1ns/1ps

// Handshake: a request is accepted in the cycle where req && gnt. The
// requester holds write/addr/wdata stable while req is high and gnt is low.
// rvalid pulses once, one cycle after a read is accepted, and qualifies rdata.
interface ram_arbiter_2x1_if #(
    parameter int DATA_W = 32
) ();
    logic              req;
    logic              write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, write, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, write, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter_2x1.sv
// Round-robin arbiter sharing one single-ported, one-cycle-latency RAM between
// an instruction-fetch port (A) and a load/store port (B).
`timescale 1ns/1ps

module ram_arbiter_2x1 #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    ram_arbiter_2x1_if.slave   port_a,
    ram_arbiter_2x1_if.slave   port_b,
    output logic [ADDR_W-1:0]  ram_address,
    output logic               ram_write,
    output logic               ram_read,
    output logic [DATA_W-1:0]  ram_writedata,
    input  logic [DATA_W-1:0]  ram_readdata,
    output logic [2:0]         dbg_state
);

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    port_e last_gnt, last_gnt_n;
    logic  pend_valid, pend_valid_n;
    port_e pend_id, pend_id_n;

    logic grant_a, grant_b, accept, sel_write;
    logic unused_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt   <= PORT_B;
            pend_valid <= 1'b0;
            pend_id    <= PORT_A;
        end else begin
            last_gnt   <= last_gnt_n;
            pend_valid <= pend_valid_n;
            pend_id    <= pend_id_n;
        end
    end

    // Grants are gated by reset_n so nothing is accepted while reset is held.
    always_comb begin
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        accept        = 1'b0;
        sel_write     = 1'b0;
        ram_address   = port_a.addr[ADDR_W+1:2];
        ram_writedata = port_a.wdata;
        ram_write     = 1'b0;
        ram_read      = 1'b0;
        last_gnt_n    = last_gnt;
        pend_valid_n  = 1'b0;
        pend_id_n     = PORT_A;

        if (reset_n) begin
            if (port_a.req && port_b.req) begin
                grant_a = (last_gnt == PORT_B);
                grant_b = (last_gnt == PORT_A);
            end else begin
                grant_a = port_a.req;
                grant_b = port_b.req;
            end
        end

        accept = grant_a | grant_b;

        if (grant_b) begin
            sel_write     = port_b.write;
            ram_address   = port_b.addr[ADDR_W+1:2];
            ram_writedata = port_b.wdata;
            last_gnt_n    = PORT_B;
            pend_id_n     = PORT_B;
        end else if (grant_a) begin
            sel_write     = port_a.write;
            last_gnt_n    = PORT_A;
        end

        ram_write    = accept & sel_write;
        ram_read     = accept & ~sel_write;
        pend_valid_n = ram_read;
    end

    assign port_a.gnt    = grant_a;
    assign port_b.gnt    = grant_b;
    // The RAM registers its output, so the pending slot lines up with readdata.
    assign port_a.rvalid = pend_valid && (pend_id == PORT_A);
    assign port_b.rvalid = pend_valid && (pend_id == PORT_B);
    assign port_a.rdata  = ram_readdata;
    assign port_b.rdata  = ram_readdata;

    assign dbg_state = {last_gnt, pend_valid, pend_id};

    assign unused_addr = ^{port_a.addr[31:ADDR_W+2], port_a.addr[1:0],
                           port_b.addr[31:ADDR_W+2], port_b.addr[1:0]};

endmodule
